// File: rtl/somatorio_n.sv
// Accumulates a run-time selected number of WIDTH-bit terms (unsigned or two's-complement).
// Define SOMATORIO_SAT_EN to saturate on overflow instead of aborting to ERRO.
module somatorio_n #(
  parameter int WIDTH      = 8,
  parameter int MAX_TERMOS = 15,
  parameter bit ASSINADO   = 1'b0,
  localparam int CW        = $clog2(MAX_TERMOS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iniciar,
  input  logic [CW-1:0]    n_termos,
  input  logic             ent_valido,
  input  logic [WIDTH-1:0] ent,
  output logic [WIDTH-1:0] soma,
  output logic             ocupado,
  output logic             pronto,
  output logic             erro,
  output logic [CW-1:0]    contagem
);

  // Handshake: a term is accepted on every rising edge where the FSM is in
  // SOMANDO and ent_valido=1; there is no back-pressure, terms may have gaps.

  typedef enum logic [1:0] {OCIOSO, SOMANDO, FIM, ERRO} estado_t;

  estado_t          estado_q, estado_d;
  logic [WIDTH-1:0] soma_q, soma_d;
  logic [CW-1:0]    cont_q, cont_d;
  logic [CW-1:0]    n_q, n_d;
  logic             erro_q, erro_d;

  logic [WIDTH:0]   soma_ext;
  logic             ovf;
  logic [CW-1:0]    cont_inc;
  logic [CW-1:0]    n_lim;

  assign soma_ext = {1'b0, soma_q} + {1'b0, ent};
  assign cont_inc = cont_q + CW'(1);
  assign n_lim    = (n_termos > CW'(MAX_TERMOS)) ? CW'(MAX_TERMOS) : n_termos;

  // Signed overflow: equal operand signs but the result sign flipped.
  always_comb begin
    if (ASSINADO)
      ovf = (soma_q[WIDTH-1] == ent[WIDTH-1]) && (soma_ext[WIDTH-1] != soma_q[WIDTH-1]);
    else
      ovf = soma_ext[WIDTH];
  end

`ifdef SOMATORIO_SAT_EN
  logic [WIDTH-1:0] satur;
  // Overflow direction follows the accumulator sign (both operands agree on it).
  always_comb begin
    if (ASSINADO)
      satur = soma_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      satur = '1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      soma_q   <= '0;
      cont_q   <= '0;
      n_q      <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      soma_q   <= soma_d;
      cont_q   <= cont_d;
      n_q      <= n_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    soma_d   = soma_q;
    cont_d   = cont_q;
    n_d      = n_q;
    erro_d   = erro_q;
    case (estado_q)
      OCIOSO, FIM, ERRO: begin
        if (iniciar) begin
          soma_d   = '0;
          cont_d   = '0;
          erro_d   = 1'b0;
          n_d      = n_lim;
          estado_d = (n_lim == '0) ? FIM : SOMANDO;
        end
      end
      SOMANDO: begin
        if (ent_valido) begin
          if (ovf) begin
`ifdef SOMATORIO_SAT_EN
            soma_d = satur;
            erro_d = 1'b1;
            cont_d = cont_inc;
            if (cont_inc == n_q) estado_d = FIM;
`else
            erro_d   = 1'b1;
            estado_d = ERRO;
`endif
          end else begin
            soma_d = soma_ext[WIDTH-1:0];
            cont_d = cont_inc;
            if (cont_inc == n_q) estado_d = FIM;
          end
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign soma     = soma_q;
  assign contagem = cont_q;
  assign erro     = erro_q;
  assign ocupado  = (estado_q == SOMANDO);
  assign pronto   = (estado_q == FIM);

endmodule

// File: tb/tb_somatorio_n.sv
// Self-checking bench for somatorio_n: one unsigned and one signed instance
// sharing data inputs, compared against an integer-range reference model.
module tb_somatorio_n;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       iniciar_u, iniciar_s;
  logic [3:0] n_termos;
  logic       ent_valido;
  logic [7:0] ent;

  logic [7:0] soma_u, soma_s;
  logic       ocupado_u, ocupado_s, pronto_u, pronto_s, erro_u, erro_s;
  logic [3:0] contagem_u, contagem_s;

  int tests = 0;
  int fails = 0;
  logic [7:0] terms_q[$];

  always #5 clk = ~clk;

  somatorio_n #(.WIDTH(8), .MAX_TERMOS(15), .ASSINADO(1'b0)) dut_u (
    .clk(clk), .reset(rst_n), .iniciar(iniciar_u), .n_termos(n_termos),
    .ent_valido(ent_valido), .ent(ent), .soma(soma_u), .ocupado(ocupado_u),
    .pronto(pronto_u), .erro(erro_u), .contagem(contagem_u)
  );

  somatorio_n #(.WIDTH(8), .MAX_TERMOS(15), .ASSINADO(1'b1)) dut_s (
    .clk(clk), .reset(rst_n), .iniciar(iniciar_s), .n_termos(n_termos),
    .ent_valido(ent_valido), .ent(ent), .soma(soma_s), .ocupado(ocupado_s),
    .pronto(pronto_s), .erro(erro_s), .contagem(contagem_s)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(string tag, bit sel, logic [7:0] es, logic [3:0] ec,
                           logic eo, logic ep, logic ee);
    logic [7:0] s;
    logic [3:0] c;
    logic       o, p, e;
    s = sel ? soma_s     : soma_u;
    c = sel ? contagem_s : contagem_u;
    o = sel ? ocupado_s  : ocupado_u;
    p = sel ? pronto_s   : pronto_u;
    e = sel ? erro_s     : erro_u;
    check({tag, ".soma"},     32'(s), 32'(es));
    check({tag, ".contagem"}, 32'(c), 32'(ec));
    check({tag, ".ocupado"},  32'(o), 32'(eo));
    check({tag, ".pronto"},   32'(p), 32'(ep));
    check({tag, ".erro"},     32'(e), 32'(ee));
  endtask

  task automatic start(bit sel, int n);
    n_termos = n[3:0];
    if (sel) iniciar_s = 1'b1;
    else     iniciar_u = 1'b1;
    tick();
    iniciar_u = 1'b0;
    iniciar_s = 1'b0;
    n_termos  = 4'($urandom);
  endtask

  task automatic feed(logic [7:0] t);
    repeat ($urandom_range(0, 2)) begin
      ent_valido = 1'b0;
      ent        = 8'($urandom);
      tick();
    end
    ent        = t;
    ent_valido = 1'b1;
    tick();
    ent_valido = 1'b0;
    ent        = 8'($urandom);
  endtask

  // Reference: integer sum with range check per accepted term.
  task automatic run_case(string tag, bit sel, int n, bit mid_start);
    int acc, cnt, err, abort, nfeed, lo, hi, v, s;
    acc = 0; cnt = 0; err = 0; abort = 0;
    lo  = sel ? -128 : 0;
    hi  = sel ? 127 : 255;
    for (int i = 0; i < n; i++) begin
      v = sel ? int'($signed(terms_q[i])) : int'(terms_q[i]);
      s = acc + v;
      if (s < lo || s > hi) begin
`ifdef SOMATORIO_SAT_EN
        acc = (s < lo) ? lo : hi;
        err = 1;
        cnt++;
`else
        abort = 1;
        break;
`endif
      end else begin
        acc = s;
        cnt++;
      end
    end
    nfeed = abort ? cnt + 1 : n;

    start(sel, n);
    if (n > 0) check({tag, ".busy_after_start"}, 32'(sel ? ocupado_s : ocupado_u), 32'd1);
    for (int i = 0; i < nfeed; i++) begin
      feed(terms_q[i]);
      if (i == nfeed - 2)
        check({tag, ".no_pronto_early"}, 32'(sel ? pronto_s : pronto_u), 32'd0);
      if (mid_start && i == 0 && nfeed > 1) begin
        n_termos = 4'd1;
        if (sel) iniciar_s = 1'b1;
        else     iniciar_u = 1'b1;
        tick();
        iniciar_u = 1'b0;
        iniciar_s = 1'b0;
      end
    end
    check_out(tag, sel, acc[7:0], abort ? cnt[3:0] : n[3:0], 1'b0, abort == 0,
              (abort != 0) || (err != 0));
    // Terms offered after completion must not disturb the held result.
    ent_valido = 1'b1;
    ent        = 8'($urandom_range(1, 255));
    repeat (2) tick();
    ent_valido = 1'b0;
    check({tag, ".hold"}, 32'(sel ? soma_s : soma_u), 32'(acc[7:0]));
  endtask

  initial begin
    rst_n      = 1'b0;
    iniciar_u  = 1'b0;
    iniciar_s  = 1'b0;
    n_termos   = '0;
    ent_valido = 1'b0;
    ent        = '0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_u", 1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_out("reset_s", 1'b1, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    terms_q = {8'd10, 8'd20, 8'd30, 8'd40};
    run_case("sum4", 1'b0, 4, 1'b0);

    terms_q = {8'd200, 8'd50, 8'd10};
    run_case("ovf_u", 1'b0, 3, 1'b0);

    terms_q = {8'd100, 8'd100};
    run_case("ovf_s", 1'b1, 2, 1'b0);

    terms_q = {8'h80, 8'hFF, 8'd5};
    run_case("neg_s", 1'b1, 3, 1'b0);

    terms_q = {};
    run_case("n_zero", 1'b0, 0, 1'b0);

    terms_q = {8'd1, 8'd2, 8'd3, 8'd4};
    run_case("mid_iniciar", 1'b0, 4, 1'b1);

    // Asynchronous reset in the middle of a run.
    start(1'b0, 5);
    feed(8'd10);
    feed(8'd20);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 8'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    terms_q = {8'd7};
    run_case("after_rst", 1'b0, 1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      int n;
      bit sel;
      sel = k[0];
      n   = $urandom_range(0, 15);
      terms_q = {};
      for (int i = 0; i < n; i++)
        terms_q.push_back(sel ? 8'($urandom) : 8'($urandom_range(0, (k < 12) ? 20 : 255)));
      run_case($sformatf("rand%0d", k), sel, n, k[1]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/somatorio_n.md
Name: somatorio_n

Overview:
Parametrised successor to the fixed 8-bit accumulator.
- Sums a run-time-selected number of WIDTH-bit terms, unsigned or two's-complement.
- Input uses a valid strobe, so terms may arrive with gaps.
- Control FSM and datapath live in one module; it drops into any design where the old 8-bit accumulator sat, with pronto/erro semantics kept.

Parameters:
- WIDTH, 8, width of each term and of soma.
- MAX_TERMOS, 15, largest selectable term count; CW = clog2(MAX_TERMOS+1).
- ASSINADO, 0, 0 = unsigned arithmetic, 1 = two's-complement arithmetic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iniciar  in  1  start pulse; sampled only in OCIOSO, FIM or ERRO.
- n_termos  in  CW  number of terms to sum; sampled on iniciar.
- ent_valido  in  1  term on ent is valid this cycle.
- ent  in  WIDTH  input term.
- soma  out  WIDTH  registered accumulator.
- ocupado  out  1  high in SOMANDO.
- pronto  out  1  high in FIM.
- erro  out  1  overflow flag.
- contagem  out  CW  terms accepted so far.

Behaviour:
- Reset (asynchronous, active-low):
  - State OCIOSO; soma=0, contagem=0, ocupado=0, pronto=0, erro=0.
  - Takes effect immediately, including mid-run; no partial result survives.
- FSM states: OCIOSO, SOMANDO, FIM, ERRO.
- Start: iniciar=1 in OCIOSO, FIM or ERRO, on the next edge:
  - soma<=0, contagem<=0, erro<=0, n latched from n_termos.
  - Latched n clamped to MAX_TERMOS if larger.
  - If n==0, go to FIM (pronto=1, soma=0); otherwise go to SOMANDO.
- iniciar in SOMANDO: ignored. n_termos changes after start: ignored.
- SOMANDO:
  - Each edge with ent_valido=1 accepts ent: soma<=soma+ent, contagem<=contagem+1.
  - Cycles with ent_valido=0 hold all state.
  - ent/ent_valido are ignored outside SOMANDO.
- Completion:
  - On the edge accepting the n-th term, go to FIM.
  - pronto=1 from the following cycle; soma is final at that point (1-cycle latency per term).
  - FIM holds soma/pronto until the next iniciar.
- Overflow detection, computed on a WIDTH+1 bit sum:
  - Unsigned (ASSINADO=0): carry out of bit WIDTH-1.
  - Signed (ASSINADO=1): both operands share a sign and the result sign differs.
- Overflow on an accepted term (macro off):
  - soma keeps its pre-overflow value; contagem is not incremented.
  - Go to ERRO; erro=1, pronto=0, ocupado=0.
  - Held until iniciar.
- Overflow on the n-th term: overflow wins; go to ERRO, not FIM.
- Outputs:
  - ocupado = (state==SOMANDO).
  - pronto and erro never both high unless SOMATORIO_SAT_EN is defined.
- Arithmetic: sign handling is fixed by ASSINADO; no runtime mode switch.

Optional Feature:
Macro SOMATORIO_SAT_EN.
- Defined:
  - Overflow clamps instead of aborting: unsigned clamps to 2^WIDTH-1; signed clamps to 2^(WIDTH-1)-1 or -2^(WIDTH-1) in the overflow direction.
  - The term counts; contagem increments and summing continues.
  - Later terms also use saturating add (clamped per step).
  - erro becomes a sticky flag set on the first clamp; the run still ends in FIM with pronto=1.
  - erro stays 1 alongside pronto; ERRO state is unreachable.
- Undefined: abort-to-ERRO behaviour above; no saturation logic is synthesised.

Test Plan:
1. WIDTH=8 unsigned, n_termos=4, terms 10,20,30,40 with ent_valido gaps:
   - soma=100, pronto=1 one cycle after the 4th accept, contagem=4, erro=0.
2. Unsigned, n_termos=3, terms 200,50,10, macro off:
   - 200+50 fine; 250+10 overflows, so ERRO with erro=1, soma=250, contagem=2, pronto=0.
3. Same stimulus, SOMATORIO_SAT_EN defined:
   - soma=255, contagem=3, pronto=1, erro=1.
4. ASSINADO=1, n_termos=2, terms 100,100 (macro off):
   - ERRO with soma=100.
   - With the macro: soma=127, pronto=1, erro=1.
   - Separate run, n_termos=3, terms -128,-1,5, macro on: -128-1 clamps to -128, then -123; final soma=-123 (0x85), erro=1.
5. n_termos=0 start:
   - FIM next cycle, soma=0, pronto=1.
   - iniciar pulsed in SOMANDO mid-run has no effect.
6. reset asserted low mid-run after 2 terms:
   - All outputs 0 asynchronously.
   - After release, a fresh iniciar with n_termos=1, term 7 gives soma=7, pronto=1.
